// File: rtl/execute_if.sv
// execute_if: ID/EX inputs, hazard controls and EX/MEM outputs of the execute stage.
interface execute_if #(parameter int XLEN = 64);
   logic            reg_write_e, result_src_e, mem_write_e, jump_e, branch_e, alu_src_e;
   logic [2:0]      alu_control_e;
   logic [XLEN-1:0] rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e;
   logic [4:0]      rd_e;
   logic [1:0]      forward_a_e, forward_b_e;
   logic [XLEN-1:0] result_w;
   logic            stall_m, flush_m;
   logic            pc_src_e;
   logic [XLEN-1:0] pc_target_e;
   logic            reg_write_m, result_src_m, mem_write_m;
   logic [XLEN-1:0] alu_result_m, write_data_m, pc_plus4_m;
   logic [4:0]      rd_m;
   modport master (
      output reg_write_e, result_src_e, mem_write_e, jump_e, branch_e, alu_src_e, alu_control_e,
             rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e, rd_e, forward_a_e, forward_b_e,
             result_w, stall_m, flush_m,
      input  pc_src_e, pc_target_e, reg_write_m, result_src_m, mem_write_m,
             alu_result_m, write_data_m, pc_plus4_m, rd_m
   );
   modport slave (
      input  reg_write_e, result_src_e, mem_write_e, jump_e, branch_e, alu_src_e, alu_control_e,
             rd1_e, rd2_e, pc_e, pc_plus4_e, imm_ext_e, rd_e, forward_a_e, forward_b_e,
             result_w, stall_m, flush_m,
      output pc_src_e, pc_target_e, reg_write_m, result_src_m, mem_write_m,
             alu_result_m, write_data_m, pc_plus4_m, rd_m
   );
endinterface

// File: rtl/execute.sv
// execute: EX stage with operand forwarding, ALU, branch resolution and the EX/MEM register.
module execute #(parameter int XLEN = 64) (
   input logic      clk,
   input logic      rst,
   execute_if.slave bus
);
   logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result;
   always_comb begin
      src_a = bus.forward_a_e == 2'b01 ? bus.result_w :
              bus.forward_a_e == 2'b10 ? bus.alu_result_m : bus.rd1_e;
      fwd_b = bus.forward_b_e == 2'b01 ? bus.result_w :
              bus.forward_b_e == 2'b10 ? bus.alu_result_m : bus.rd2_e;
      src_b = bus.alu_src_e ? bus.imm_ext_e : fwd_b;
   end
   always_comb begin
      case (bus.alu_control_e)
         3'b000:  alu_result = src_a + src_b;
         3'b001:  alu_result = src_a - src_b;
         3'b010:  alu_result = src_a & src_b;
         3'b011:  alu_result = src_a | src_b;
         3'b100:  alu_result = src_a ^ src_b;
         3'b101:  alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
         3'b110:  alu_result = src_a << src_b[5:0];
         default: alu_result = src_a >> src_b[5:0];
      endcase
   end
   // Redirect is purely combinational and deliberately blind to stall/flush.
   assign bus.pc_src_e    = bus.jump_e | (bus.branch_e & (alu_result == '0));
   assign bus.pc_target_e = bus.pc_e + bus.imm_ext_e;
   always_ff @(posedge clk or posedge rst) begin
      if (rst || bus.flush_m) begin
         bus.reg_write_m  <= 1'b0;
         bus.result_src_m <= 1'b0;
         bus.mem_write_m  <= 1'b0;
         bus.alu_result_m <= '0;
         bus.write_data_m <= '0;
         bus.pc_plus4_m   <= '0;
         bus.rd_m         <= '0;
      end else if (!bus.stall_m) begin
         bus.reg_write_m  <= bus.reg_write_e;
         bus.result_src_m <= bus.result_src_e;
         bus.mem_write_m  <= bus.mem_write_e;
         bus.alu_result_m <= alu_result;
         bus.write_data_m <= fwd_b;
         bus.pc_plus4_m   <= bus.pc_plus4_e;
         bus.rd_m         <= bus.rd_e;
      end
   end
endmodule

// File: tb/tb_execute.sv
// tb_execute: directed vectors for execute, checked every cycle against a behavioural model.
module tb_execute;
   typedef struct packed {
      logic        rw, rs, mw;
      logic [63:0] alu, wd, pc4;
      logic [4:0]  rd;
   } mstate_t;

   logic    clk, rst;
   int      compared = 0, failed = 0;
   mstate_t m;

   execute_if #(64) bus();
   execute #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   function automatic logic [63:0] ref_alu(input logic [2:0] op, input logic [63:0] a, b);
      logic signed [63:0] sa, sb;
      sa = a;
      sb = b;
      if (op == 3'd0) return a + b;
      if (op == 3'd1) return a - b;
      if (op == 3'd2) return a & b;
      if (op == 3'd3) return a | b;
      if (op == 3'd4) return a ^ b;
      if (op == 3'd5) return (sa < sb) ? 64'd1 : 64'd0;
      if (op == 3'd6) return a << (b % 64);
      return a >> (b % 64);
   endfunction

   function automatic logic [63:0] pick(input logic [1:0] sel, input logic [63:0] reg_val);
      return sel == 2'd1 ? bus.result_w : sel == 2'd2 ? m.alu : reg_val;
   endfunction

   function automatic logic [63:0] ref_result();
      logic [63:0] b;
      b = bus.alu_src_e ? bus.imm_ext_e : pick(bus.forward_b_e, bus.rd2_e);
      return ref_alu(bus.alu_control_e, pick(bus.forward_a_e, bus.rd1_e), b);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst || bus.flush_m) m <= '0;
      else if (!bus.stall_m)
         m <= '{bus.reg_write_e, bus.result_src_e, bus.mem_write_e, ref_result(),
                pick(bus.forward_b_e, bus.rd2_e), bus.pc_plus4_e, bus.rd_e};
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      compared++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("pc_src_e", 64'(bus.pc_src_e), 64'(bus.jump_e | (bus.branch_e & (ref_result() == 0))));
      chk("pc_target_e", bus.pc_target_e, bus.pc_e + bus.imm_ext_e);
      chk("reg_write_m", 64'(bus.reg_write_m), 64'(m.rw));
      chk("result_src_m", 64'(bus.result_src_m), 64'(m.rs));
      chk("mem_write_m", 64'(bus.mem_write_m), 64'(m.mw));
      chk("alu_result_m", bus.alu_result_m, m.alu);
      chk("write_data_m", bus.write_data_m, m.wd);
      chk("pc_plus4_m", bus.pc_plus4_m, m.pc4);
      chk("rd_m", 64'(bus.rd_m), 64'(m.rd));
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      {bus.reg_write_e, bus.result_src_e, bus.mem_write_e, bus.jump_e, bus.branch_e, bus.alu_src_e} = '0;
      bus.alu_control_e = 0;
      {bus.rd1_e, bus.rd2_e, bus.pc_e, bus.pc_plus4_e, bus.imm_ext_e, bus.result_w} = '0;
      bus.rd_e = 0;
      bus.forward_a_e = 0;
      bus.forward_b_e = 0;
      bus.stall_m = 0;
      bus.flush_m = 0;
   endtask

   task automatic chk_bubble(input string name);
      chk({name, "_alu"}, bus.alu_result_m, 0);
      chk({name, "_wd"}, bus.write_data_m, 0);
      chk({name, "_pc4"}, bus.pc_plus4_m, 0);
      chk({name, "_ctl"}, 64'({bus.reg_write_m, bus.result_src_m, bus.mem_write_m, bus.rd_m}), 0);
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [63:0] a, b, y;
   } vec_t;
   vec_t vecs[5] = '{
      '{3'd1, 64'd10, 64'd3, 64'd7},
      '{3'd2, 64'hF0, 64'h3C, 64'h30},
      '{3'd3, 64'hF0, 64'h0F, 64'hFF},
      '{3'd4, 64'hFF, 64'h0F, 64'hF0},
      '{3'd7, 64'h8000_0000_0000_0000, 64'd63, 64'd1}
   };

   initial begin
      rst = 0;
      idle();
      #1 rst = 1;
      #2 chk_bubble("reset");
      step();
      step();
      rst = 0;
      // ADD, no forwarding
      bus.rd1_e = 5; bus.rd2_e = 7; bus.rd_e = 3; bus.reg_write_e = 1;
      bus.pc_plus4_e = 64'h44; bus.result_src_e = 1; bus.mem_write_e = 1;
      step();
      chk("add_alu", bus.alu_result_m, 12);
      chk("add_wd", bus.write_data_m, 7);
      chk("add_rd", 64'(bus.rd_m), 3);
      chk("add_rw", 64'(bus.reg_write_m), 1);
      chk("add_pc4", bus.pc_plus4_m, 64'h44);
      // BEQ taken / not taken
      idle();
      bus.branch_e = 1; bus.alu_control_e = 3'b001; bus.rd1_e = 9; bus.rd2_e = 9;
      bus.pc_e = 64'h100; bus.imm_ext_e = 64'h20;
      #1 chk("beq_taken", 64'(bus.pc_src_e), 1);
      chk("beq_target", bus.pc_target_e, 64'h120);
      bus.rd2_e = 8;
      #1 chk("beq_not_taken", 64'(bus.pc_src_e), 0);
      bus.jump_e = 1;
      #1 chk("jump", 64'(bus.pc_src_e), 1);
      step();
      // Forwarding from EX/MEM and writeback
      idle();
      bus.rd1_e = 64'h40;
      step();
      bus.rd1_e = 64'h999; bus.rd2_e = 64'h777; bus.result_w = 3;
      bus.forward_a_e = 2'b10; bus.forward_b_e = 2'b01;
      step();
      chk("fwd_alu", bus.alu_result_m, 64'h43);
      chk("fwd_wd", bus.write_data_m, 3);
      // Stall holds, forwarding still sees held value
      idle();
      bus.stall_m = 1; bus.rd1_e = 1; bus.rd2_e = 2; bus.reg_write_e = 1; bus.rd_e = 9;
      step();
      bus.rd1_e = 11; bus.branch_e = 1; bus.alu_control_e = 3'b001;
      bus.forward_a_e = 2'b10; bus.rd2_e = 64'h43;
      #1 chk("stall_fwd_branch", 64'(bus.pc_src_e), 1);
      step();
      chk("stall_alu", bus.alu_result_m, 64'h43);
      chk("stall_wd", bus.write_data_m, 3);
      chk("stall_rd", 64'(bus.rd_m), 0);
      bus.flush_m = 1;
      step();
      chk_bubble("flush");
      // Wrap, SLT, shifts and the remaining ops
      idle();
      bus.rd1_e = '1; bus.imm_ext_e = 1; bus.alu_src_e = 1; bus.rd2_e = 64'h55;
      step();
      chk("wrap_add", bus.alu_result_m, 0);
      chk("wrap_wd_not_imm", bus.write_data_m, 64'h55);
      idle();
      bus.rd1_e = '1; bus.rd2_e = 1; bus.alu_control_e = 3'b101;
      step();
      chk("slt", bus.alu_result_m, 1);
      bus.rd1_e = 1; bus.imm_ext_e = 65; bus.alu_src_e = 1; bus.alu_control_e = 3'b110;
      step();
      chk("sll65", bus.alu_result_m, 2);
      idle();
      foreach (vecs[i]) begin
         bus.alu_control_e = vecs[i].op; bus.rd1_e = vecs[i].a; bus.rd2_e = vecs[i].b;
         step();
         chk("vec_alu", bus.alu_result_m, vecs[i].y);
      end
      // Asynchronous reset mid-operation
      idle();
      bus.rd1_e = 5; bus.rd2_e = 7; bus.rd_e = 4; bus.reg_write_e = 1;
      step();
      #1 rst = 1;
      #1 chk_bubble("async_rst");
      bus.pc_e = 64'h200; bus.imm_ext_e = 64'h10;
      #1 chk("rst_target", bus.pc_target_e, 64'h210);
      step();
      bus.rd1_e = 1; bus.rd2_e = 2; bus.imm_ext_e = 0;
      rst = 0;
      step();
      chk("first_capture", bus.alu_result_m, 3);
      chk("first_capture_rd", 64'(bus.rd_m), 4);
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end
endmodule
